// File: rtl/blink_led.sv
// Free-running LED blinker: a binary up-counter clocked by clk, with one
// selected counter bit (optionally inverted) driving the LED pin.
`timescale 1ns/1ps

module blink_led #(
    parameter int CNT_WIDTH  = 27,
    parameter int LED_BIT    = CNT_WIDTH - 1,
    parameter bit LED_INVERT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    output logic led
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Reject illegal parameter combinations at elaboration.
    generate
        if (CNT_WIDTH < 2) begin : g_bad_width
            $fatal(1, "blink_led: CNT_WIDTH must be at least 2");
        end
        if (LED_BIT >= CNT_WIDTH || LED_BIT < 0) begin : g_bad_led_bit
            $fatal(1, "blink_led: LED_BIT must lie in 0..CNT_WIDTH-1");
        end
    endgenerate

    logic [CNT_WIDTH-1:0] cnt;

    // rst is active-low; the clear is asynchronous, the release takes effect
    // on the next rising edge, and wrap-around is plain modulo arithmetic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // XOR with a constant folds to a wire or inverter, so led remains a
    // glitch-free function of a single flop.
    assign led = cnt[LED_BIT] ^ LED_INVERT;

endmodule

// File: tb/tb_blink_led.sv
// Self-checking bench for blink_led: three parameterisations checked every cycle
// against an edge-count reference model, plus fixed vectors and random resets.
`timescale 1ns/1ps

module tb_blink_led;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;
    logic led_a;
    logic led_b;
    logic led_c;

    int checks;
    int passes;
    int k_a;
    int k_b;
    int k_c;

    typedef struct {
        int         edge_n;
        logic [3:0] exp_cnt;
        logic       exp_led;
    } vec_t;

    vec_t vecs [14];

    blink_led #(.CNT_WIDTH(4), .LED_BIT(3), .LED_INVERT(1'b0)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .led (led_a)
    );

    blink_led #(.CNT_WIDTH(4), .LED_BIT(0), .LED_INVERT(1'b1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .led (led_b)
    );

    blink_led dut_c (
        .clk (clk),
        .rst (rst_c),
        .led (led_c)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: led is bit LED_BIT of (edges since release mod 2^CNT_WIDTH),
    // XOR the inversion flag; during reset the counter reads zero.
    function automatic logic [31:0] model_led(input int edges, input int width,
                                              input int bit_sel, input int inv, input bit in_rst);
        int c;
        c = in_rst ? 0 : (edges % (1 << width));
        return 32'(((c >> bit_sel) & 1) ^ inv);
    endfunction

    task automatic step();
        @(posedge clk);
        #0.5;
        if (rst_a) k_a++;
        if (rst_b) k_b++;
        if (rst_c) k_c++;
        check("a_led_model", 32'(led_a), model_led(k_a, 4, 3, 0, !rst_a));
        check("a_cnt_model", 32'(dut_a.cnt), rst_a ? 32'(k_a % 16) : 32'd0);
        check("b_led_model", 32'(led_b), model_led(k_b, 4, 0, 1, !rst_b));
        check("c_led_model", 32'(led_c), 32'd0);
        if (k_c == 250) check("c_cnt_after_500ns", 32'(dut_c.cnt), 32'd250);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        k_a = 0;
        k_b = 0;
        k_c = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        vecs[0]  = '{1,   4'd1,  1'b0};
        vecs[1]  = '{7,   4'd7,  1'b0};
        vecs[2]  = '{8,   4'd8,  1'b1};
        vecs[3]  = '{15,  4'd15, 1'b1};
        vecs[4]  = '{16,  4'd0,  1'b0};
        vecs[5]  = '{24,  4'd8,  1'b1};
        vecs[6]  = '{32,  4'd0,  1'b0};
        vecs[7]  = '{46,  4'd14, 1'b1};
        vecs[8]  = '{47,  4'd15, 1'b1};
        vecs[9]  = '{48,  4'd0,  1'b0};
        vecs[10] = '{49,  4'd1,  1'b0};
        vecs[11] = '{120, 4'd8,  1'b1};
        vecs[12] = '{128, 4'd0,  1'b0};
        vecs[13] = '{248, 4'd8,  1'b1};

        // Reset hold for 200 ns with the clock running.
        #0.5;
        check("reset_led_a_t0", 32'(led_a), 32'd0);
        check("reset_led_b_inverted", 32'(led_b), 32'd1);
        repeat (100) step();

        rst_a = 1'b1;
        rst_c = 1'b1;

        for (int i = 0; i < 14; i++) begin
            while (k_a < vecs[i].edge_n) step();
            check($sformatf("vec_led_edge%0d", vecs[i].edge_n), 32'(led_a), 32'(vecs[i].exp_led));
            check($sformatf("vec_cnt_edge%0d", vecs[i].edge_n), 32'(dut_a.cnt), 32'(vecs[i].exp_cnt));
        end

        // Async reset between edges while led is high.
        while (k_a < 264) step();
        check("led_high_before_async_rst", 32'(led_a), 32'd1);
        #0.4;
        rst_a = 1'b0;
        #0.1;
        check("async_clear_led", 32'(led_a), 32'd0);
        check("async_clear_cnt", 32'(dut_a.cnt), 32'd0);
        k_a = 0;
        repeat (3) step();
        rst_a = 1'b1;
        repeat (7) step();
        check("restart_led_edge7", 32'(led_a), 32'd0);
        step();
        check("restart_led_edge8", 32'(led_a), 32'd1);

        // Inverted output on bit 0 alternates every edge.
        check("b_led_in_reset", 32'(led_b), 32'd1);
        rst_b = 1'b1;
        step();
        check("b_led_edge1", 32'(led_b), 32'd0);
        step();
        check("b_led_edge2", 32'(led_b), 32'd1);
        step();
        check("b_led_edge3", 32'(led_b), 32'd0);

        // Random run lengths and randomly placed reset pulses, including glitches.
        repeat (25) begin
            int r;
            int u;
            int h;
            r = $urandom_range(1, 40);
            repeat (r) step();
            u = $urandom_range(0, 8);
            #(u * 0.1);
            rst_a = 1'b0;
            rst_b = 1'b0;
            #0.05;
            check("rand_async_led_a", 32'(led_a), 32'd0);
            check("rand_async_cnt_a", 32'(dut_a.cnt), 32'd0);
            check("rand_async_led_b", 32'(led_b), 32'd1);
            k_a = 0;
            k_b = 0;
            h = $urandom_range(0, 3);
            if (h == 0) begin
                #0.2;
            end else begin
                repeat (h) step();
            end
            rst_a = 1'b1;
            rst_b = 1'b1;
        end
        repeat (20) step();

        if (k_c < 250) check("c_reached_250_edges", 32'(k_c), 32'd250);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
